// File: rtl/barrett_reduce60.sv
`default_nettype none
// ============================================================================
// barrett_reduce60 : c mod q for 60-bit products, 4-stage elastic Barrett pipe
// Optional BARRETT_LAZY_EN : one final subtraction, 31-bit result in [0, 2q)
// Revision 1.0 : initial release
// ============================================================================
module barrett_reduce60 #(
   parameter int K   = 30,
   parameter int LAT = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cfg_load,
   input  logic [K-1:0]     q_in,
   input  logic [K:0]       mu_in,
   output logic             busy,
   input  logic             in_valid,
   input  logic [2*K-1:0]   in_data,
   output logic             in_ready,
   output logic             out_valid,
`ifdef BARRETT_LAZY_EN
   output logic [K:0]       out_data,
`else
   output logic [K-1:0]     out_data,
`endif
   input  logic             out_ready
);

`ifdef BARRETT_LAZY_EN
   localparam int OW = K + 1;
`else
   localparam int OW = K;
`endif
   localparam int CW = 2 * K;
   localparam int RW = K + 2;

   logic             adv;
   logic [LAT-1:0]   vld_q,    vld_d;
   logic [K-1:0]     mod_q,    mod_d;
   logic [K:0]       mu_q,     mu_d;
   logic [CW-1:0]    s1_c_q,   s1_c_d;
   logic [K:0]       s2_q3_q,  s2_q3_d;
   logic [RW-1:0]    s2_clo_q, s2_clo_d;
   logic [RW-1:0]    s3_r_q,   s3_r_d;
   logic [OW-1:0]    s4_r_q,   s4_r_d;
   logic             outv_q,   outv_d;
   logic [OW-1:0]    outd_q,   outd_d;

   logic [K:0]       q1;
   logic [2*K+1:0]   prod1;
   logic [2*K:0]     prod2;
   logic [RW-1:0]    mod_ext;
   logic [RW-1:0]    red1;
`ifndef BARRETT_LAZY_EN
   logic [RW-1:0]    red2;
`endif
   logic             unused_bits;

   always_comb begin
      adv     = ~outv_q | out_ready;

      q1      = s1_c_q[CW-1:K-1];
      prod1   = {{(K+1){1'b0}}, q1} * {{(K+1){1'b0}}, mu_q};
      prod2   = {{K{1'b0}}, s2_q3_q} * {{(K+1){1'b0}}, mod_q};
      mod_ext = {2'b00, mod_q};
      // Remainder entering the last stage is below 3q, so two trims suffice.
      red1    = (s3_r_q >= mod_ext) ? (s3_r_q - mod_ext) : s3_r_q;
`ifndef BARRETT_LAZY_EN
      red2    = (red1 >= mod_ext) ? (red1 - mod_ext) : red1;
`endif

      vld_d    = vld_q;
      mod_d    = mod_q;
      mu_d     = mu_q;
      s1_c_d   = s1_c_q;
      s2_q3_d  = s2_q3_q;
      s2_clo_d = s2_clo_q;
      s3_r_d   = s3_r_q;
      s4_r_d   = s4_r_q;
      outv_d   = outv_q;
      outd_d   = outd_q;

      if (cfg_load && !busy) begin
         mod_d = q_in;
         mu_d  = mu_in;
      end

      if (adv) begin
         vld_d    = {vld_q[LAT-2:0], in_valid};
         s1_c_d   = in_data;
         s2_q3_d  = prod1[2*K+1:K+1];
         s2_clo_d = s1_c_q[RW-1:0];
         s3_r_d   = s2_clo_q - prod2[RW-1:0];
`ifdef BARRETT_LAZY_EN
         s4_r_d   = red1[OW-1:0];
`else
         s4_r_d   = red2[OW-1:0];
`endif
         outv_d   = vld_q[LAT-1];
         outd_d   = s4_r_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_q    <= '0;
         mod_q    <= '0;
         mu_q     <= '0;
         s1_c_q   <= '0;
         s2_q3_q  <= '0;
         s2_clo_q <= '0;
         s3_r_q   <= '0;
         s4_r_q   <= '0;
         outv_q   <= 1'b0;
         outd_q   <= '0;
      end else begin
         vld_q    <= vld_d;
         mod_q    <= mod_d;
         mu_q     <= mu_d;
         s1_c_q   <= s1_c_d;
         s2_q3_q  <= s2_q3_d;
         s2_clo_q <= s2_clo_d;
         s3_r_q   <= s3_r_d;
         s4_r_q   <= s4_r_d;
         outv_q   <= outv_d;
         outd_q   <= outd_d;
      end
   end

   assign busy      = |vld_q;
   assign in_ready  = adv;
   assign out_valid = outv_q;
   assign out_data  = outd_q;

`ifdef BARRETT_LAZY_EN
   assign unused_bits = ^{prod1[K:0], prod2[2*K:RW], red1[RW-1:OW]};
`else
   assign unused_bits = ^{prod1[K:0], prod2[2*K:RW], red2[RW-1:OW]};
`endif

endmodule
`default_nettype wire
